// File: rtl/led_blink_seq.sv
// Blink-sequence generator: on a one-cycle start it drives the LED through
// `count` on/off blinks with millisecond timing, then pulses done.
module led_blink_seq #(
  parameter int   sclk_freq = 50_000_000,
  parameter logic on_vol    = 1'b1,
  parameter int   on_ms     = 200,
  parameter int   off_ms    = 200,
  parameter int   cnt_width = 4
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cnt_width-1:0] count,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 led
);

  localparam int MS      = sclk_freq / 1000;
  localparam int ON_CYC  = on_ms * MS;
  localparam int OFF_CYC = off_ms * MS;
  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYC - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [PH_W-1:0]       r_phase, w_phase_nxt;
  logic [cnt_width-1:0]  r_remain, w_remain_nxt;
  logic                  r_led, w_led_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase + PH_W'(1);
    w_remain_nxt = r_remain;
    w_led_nxt    = r_led;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        // abort outranks start even while idle
        if (start && !abort) begin
          if (count != '0) begin
            w_state_nxt  = S_ON;
            w_remain_nxt = count;
            w_led_nxt    = on_vol;
            w_busy_nxt   = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end

      S_ON: begin
        if (abort) begin
          w_state_nxt  = S_IDLE;
          w_phase_nxt  = '0;
          w_remain_nxt = '0;
          w_led_nxt    = !on_vol;
          w_busy_nxt   = 1'b0;
        end else if (r_phase == ON_LAST) begin
          w_state_nxt = S_OFF;
          w_phase_nxt = '0;
          w_led_nxt   = !on_vol;
        end
      end

      S_OFF: begin
        if (abort) begin
          w_state_nxt  = S_IDLE;
          w_phase_nxt  = '0;
          w_remain_nxt = '0;
          w_led_nxt    = !on_vol;
          w_busy_nxt   = 1'b0;
        end else if (r_phase == OFF_LAST) begin
          w_phase_nxt  = '0;
          w_remain_nxt = r_remain - cnt_width'(1);
          // last blink finished: completion is reported on the IDLE entry cycle
          if (r_remain == cnt_width'(1)) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ON;
            w_led_nxt   = on_vol;
          end
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_phase_nxt  = '0;
        w_remain_nxt = '0;
        w_led_nxt    = !on_vol;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_remain <= '0;
      r_led    <= !on_vol;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_remain <= w_remain_nxt;
      r_led    <= w_led_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign led  = r_led;

endmodule

// File: tb/tb_led_blink_seq.sv
// Scoreboard bench for led_blink_seq: a cycle-level model derived from the
// blink timing rules predicts led/busy each cycle and the cycle of every done.
module tb_led_blink_seq;

  localparam int SCLK_FREQ = 10_000;
  localparam int ON_MS     = 3;
  localparam int OFF_MS    = 2;
  localparam int CNT_W     = 4;
  localparam int ON_CYC    = ON_MS * (SCLK_FREQ / 1000);
  localparam int OFF_CYC   = OFF_MS * (SCLK_FREQ / 1000);
  localparam int PERIOD    = ON_CYC + OFF_CYC;

  logic             sclk  = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             busy, done, led;

  led_blink_seq #(
    .sclk_freq (SCLK_FREQ),
    .on_vol    (1'b1),
    .on_ms     (ON_MS),
    .off_ms    (OFF_MS),
    .cnt_width (CNT_W)
  ) dut (
    .sclk  (sclk),
    .rst   (rst),
    .start (start),
    .count (count),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .led   (led)
  );

  always #5 sclk = ~sclk;

  int cyc        = 0;
  bit run_active = 1'b0;
  int run_k      = 0;
  int run_n      = 0;
  int exp_done_q[$];
  int n_checks   = 0;
  int n_fail     = 0;

  // Busy window of the current run: cycles k+1 .. k+N*PERIOD.
  function automatic bit m_busy(int c);
    return run_active && (c > run_k) && (c <= run_k + run_n * PERIOD);
  endfunction

  function automatic bit m_led(int c);
    return m_busy(c) && (((c - run_k - 1) % PERIOD) < ON_CYC);
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: consume the inputs of the cycle that just ended.
  always @(posedge sclk) begin
    if (!rst) begin
      if (m_busy(cyc)) begin
        if (abort) begin
          run_active = 1'b0;
          if (exp_done_q.size() > 0) void'(exp_done_q.pop_back());
        end
      end else if (start && !abort) begin
        if (count == '0) begin
          exp_done_q.push_back(cyc + 1);
        end else begin
          run_active = 1'b1;
          run_k      = cyc;
          run_n      = int'(count);
          exp_done_q.push_back(cyc + run_n * PERIOD + 1);
        end
      end
    end
    cyc++;
  end

  // Monitor: compare levels every cycle, and each done pulse against the queue.
  always @(negedge sclk) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy(cyc)});
    check("led", {31'd0, led}, {31'd0, m_led(cyc)});
    while (exp_done_q.size() > 0 && exp_done_q[0] < cyc) begin
      check("done_missing", cyc, exp_done_q[0]);
      void'(exp_done_q.pop_front());
    end
    if (done !== 1'b0) begin
      if (exp_done_q.size() == 0) check("done_spurious", {31'd0, done}, 32'd0);
      else check("done_cycle", cyc, exp_done_q.pop_front());
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic issue_start(int n);
    start = 1'b1;
    count = CNT_W'(n);
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
    step(5);

    // three blinks, then a zero-count request
    issue_start(3);
    step(160);
    issue_start(0);
    step(5);

    // start while busy is ignored
    issue_start(2);
    step(39);
    issue_start(5);
    step(70);

    // abort mid-sequence, then a fresh single blink
    issue_start(4);
    step(59);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(9);
    issue_start(1);
    step(60);

    // abort and start together in idle: abort wins
    abort = 1'b1;
    start = 1'b1;
    count = CNT_W'(2);
    step(1);
    abort = 1'b0;
    start = 1'b0;
    step(5);

    // asynchronous reset in the middle of an ON phase
    issue_start(3);
    step(14);
    #2 rst = 1'b1;
    run_active = 1'b0;
    exp_done_q.delete();
    #1;
    check("rst_led", {31'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    step(3);
    #2 rst = 1'b0;
    step(20);

    // back-to-back: new start accepted in the done cycle
    issue_start(3);
    step(150);
    issue_start(3);
    step(160);

    // all-ones count
    issue_start((1 << CNT_W) - 1);
    step(760);

    // random free-run of starts, counts and aborts
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 47) == 0);
      abort = ($urandom_range(0, 299) == 0);
      count = CNT_W'($urandom_range(0, 5));
      step(1);
    end
    start = 1'b0;
    abort = 1'b0;
    step(300);

    check("done_queue_empty", exp_done_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
